// File: rtl/router_rd_if.sv
// Read-side bundle between a router output FIFO/synchroniser and its destination read agent.
// The master modport is the read agent; the slave modport is the FIFO side.
interface router_rd_if #(
    parameter int DATA_W = 8,
    parameter int DLY_W  = 5
);
    logic              vld_out;
    logic [DATA_W-1:0] data_out;
    logic              soft_reset;
    logic [DLY_W-1:0]  start_dly;
    logic              read_enb;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic [1:0]        pkt_addr;
    logic [DATA_W-3:0] pkt_len;
    logic              pkt_done;
    logic              pkt_err;
    logic              pkt_abort;
    logic              busy;

    modport master (
        input  vld_out, data_out, soft_reset, start_dly,
        output read_enb, rx_valid, rx_data, pkt_addr, pkt_len,
               pkt_done, pkt_err, pkt_abort, busy
    );

    modport slave (
        output vld_out, data_out, soft_reset, start_dly,
        input  read_enb, rx_valid, rx_data, pkt_addr, pkt_len,
               pkt_done, pkt_err, pkt_abort, busy
    );
endinterface

// File: rtl/router_rd_client.sv
// Destination read agent for one router output port: delays after vld_out, drains one packet,
// checks parity. Define ROUTER_RD_PARITY_CHK_EN to enable the parity comparison (pkt_err).
module router_rd_client #(
    parameter int DATA_W = 8,
    parameter int DLY_W  = 5
) (
    input  logic         clk,
    input  logic         resetn,
    router_rd_if.master  bus
);
    localparam int CNT_W = DATA_W - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_READ = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic              hdr_known_q, hdr_known_d;
    logic              rx_valid_q, rx_valid_d;
    logic [1:0]        pkt_addr_q, pkt_addr_d;
    logic [DATA_W-3:0] pkt_len_q, pkt_len_d;
    logic              pkt_abort_q, pkt_abort_d;

    logic [CNT_W-1:0]  total;
    logic [CNT_W-1:0]  rd_limit;
    logic              abort;
    logic              read_enb;
    logic              last_byte;
    logic              pkt_done;

    // Until the header returns only two reads are safe: the shortest packet is header + parity.
    assign total    = CNT_W'(pkt_len_q) + CNT_W'(2);
    assign rd_limit = hdr_known_q ? total : CNT_W'(2);
    assign abort    = bus.soft_reset && (state_q != S_IDLE);
    assign read_enb = (state_q == S_READ) && bus.vld_out && !bus.soft_reset &&
                      (rd_cnt_q < rd_limit);
    assign last_byte = (state_q == S_READ) && rx_valid_q && hdr_known_q &&
                       (rx_cnt_q == total - CNT_W'(1));
    assign pkt_done  = last_byte && !abort;

`ifdef ROUTER_RD_PARITY_CHK_EN
    logic [DATA_W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (abort || last_byte) begin
            acc_d = '0;
        end else if (rx_valid_q && (state_q == S_READ)) begin
            acc_d = acc_q ^ bus.data_out;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) acc_q <= '0;
        else         acc_q <= acc_d;
    end

    assign bus.pkt_err = pkt_done && (acc_q != bus.data_out);
`else
    assign bus.pkt_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        dly_cnt_d   = dly_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        hdr_known_d = hdr_known_q;
        pkt_addr_d  = pkt_addr_q;
        pkt_len_d   = pkt_len_q;
        rx_valid_d  = read_enb;
        pkt_abort_d = abort;

        case (state_q)
            S_IDLE: begin
                if (bus.vld_out) begin
                    state_d   = S_WAIT;
                    dly_cnt_d = bus.start_dly;
                end
            end
            S_WAIT: begin
                if (dly_cnt_q == '0) state_d = S_READ;
                else                 dly_cnt_d = dly_cnt_q - DLY_W'(1);
            end
            S_READ: begin
                if (read_enb) rd_cnt_d = rd_cnt_q + CNT_W'(1);
                if (rx_valid_q) begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                    if (!hdr_known_q) begin
                        hdr_known_d = 1'b1;
                        pkt_addr_d  = bus.data_out[1:0];
                        pkt_len_d   = bus.data_out[DATA_W-1:2];
                    end
                end
                if (last_byte) begin
                    state_d     = S_IDLE;
                    rd_cnt_d    = '0;
                    rx_cnt_d    = '0;
                    hdr_known_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A soft reset discards whatever is in flight, including a parity byte arriving now.
        if (abort) begin
            state_d     = S_IDLE;
            dly_cnt_d   = '0;
            rd_cnt_d    = '0;
            rx_cnt_d    = '0;
            hdr_known_d = 1'b0;
            pkt_addr_d  = pkt_addr_q;
            pkt_len_d   = pkt_len_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            dly_cnt_q   <= '0;
            rd_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            hdr_known_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            pkt_addr_q  <= '0;
            pkt_len_q   <= '0;
            pkt_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_cnt_q   <= dly_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            hdr_known_q <= hdr_known_d;
            rx_valid_q  <= rx_valid_d;
            pkt_addr_q  <= pkt_addr_d;
            pkt_len_q   <= pkt_len_d;
            pkt_abort_q <= pkt_abort_d;
        end
    end

    assign bus.read_enb  = read_enb;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_data   = rx_valid_q ? bus.data_out : '0;
    assign bus.pkt_addr  = pkt_addr_q;
    assign bus.pkt_len   = pkt_len_q;
    assign bus.pkt_done  = pkt_done;
    assign bus.pkt_abort = pkt_abort_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_router_rd_client.sv
// Scoreboard bench for router_rd_client: a behavioural FIFO feeds packets, expected bytes and
// completion status are queued on push and checked as the agent returns them.
module tb_router_rd_client;
    localparam int DATA_W = 8;
    localparam int DLY_W  = 5;
`ifdef ROUTER_RD_PARITY_CHK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    router_rd_if #(.DATA_W(DATA_W), .DLY_W(DLY_W)) bus ();

    router_rd_client #(.DATA_W(DATA_W), .DLY_W(DLY_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Behavioural FIFO: one-cycle read latency, flushed by soft_reset or resetn.
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr    = '0;
    logic [7:0] rd_ptr    = '0;
    logic [7:0] dout_r    = '0;
    logic       vld_gate  = 1'b1;
    logic       soft_rst  = 1'b0;
    logic [4:0] start_dly = '0;
    int         rd_count  = 0;
    int         ovr_count = 0;

    assign bus.vld_out    = (wr_ptr != rd_ptr) && vld_gate;
    assign bus.data_out   = dout_r;
    assign bus.soft_reset = soft_rst;
    assign bus.start_dly  = start_dly;

    always @(posedge clk) begin
        if (!resetn || soft_rst) begin
            rd_ptr <= wr_ptr;
        end else if (bus.read_enb) begin
            if (!bus.vld_out) ovr_count <= ovr_count + 1;
            dout_r   <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 8'd1;
            rd_count <= rd_count + 1;
        end
    end

    logic [7:0] exp_q[$];
    bit         exp_err_q[$];
    logic [1:0] exp_addr_q[$];
    logic [5:0] exp_len_q[$];

    int checks = 0, failures = 0;
    int done_cnt = 0, abort_cnt = 0, rx_cnt = 0, wait_cnt = 0;
    bit seen_rd = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.read_enb, bus.rx_valid, bus.rx_data, bus.pkt_addr, bus.pkt_len,
                     bus.pkt_done, bus.pkt_err, bus.pkt_abort, bus.busy});
    endfunction

    task automatic tick();
        @(negedge clk);
        if (bus.busy && !bus.read_enb && !seen_rd) wait_cnt++;
        if (bus.read_enb) seen_rd = 1'b1;
        if (bus.rx_valid) begin
            rx_cnt++;
            if (exp_q.size() == 0) chk("rx_unexpected", 1, 0);
            else                   chk("rx_data", int'(bus.rx_data), int'(exp_q.pop_front()));
        end
        if (bus.pkt_done) begin
            done_cnt++;
            if (exp_err_q.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                chk("pkt_err",  int'(bus.pkt_err),  int'(exp_err_q.pop_front()));
                chk("pkt_addr", int'(bus.pkt_addr), int'(exp_addr_q.pop_front()));
                chk("pkt_len",  int'(bus.pkt_len),  int'(exp_len_q.pop_front()));
            end
        end else if (bus.pkt_err) begin
            chk("err_without_done", 1, 0);
        end
        if (bus.pkt_abort) abort_cnt++;
    endtask

    task automatic put(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 8'd1;
        exp_q.push_back(b);
    endtask

    task automatic push_pkt(input logic [1:0] addr, input int len, input logic [7:0] seed,
                            input bit corrupt);
        logic [7:0] b, par;
        logic [5:0] l6;
        l6  = 6'(len);
        b   = {l6, addr};
        par = b;
        put(b);
        for (int i = 0; i < len; i++) begin
            b   = 8'(seed * (i + 1));
            par = par ^ b;
            put(b);
        end
        put(corrupt ? (par ^ 8'h01) : par);
        exp_err_q.push_back(corrupt && PAR_EN);
        exp_addr_q.push_back(addr);
        exp_len_q.push_back(l6);
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && done_cnt < target; i++) tick();
        chk(tag, done_cnt, target);
    endtask

    task automatic wait_rx(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && rx_cnt < target; i++) tick();
        chk(tag, (rx_cnt >= target) ? 1 : 0, 1);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        exp_err_q.delete();
        exp_addr_q.delete();
        exp_len_q.delete();
    endtask

    int r0, a0, d0;

    initial begin
        #2 resetn = 1'b0;
        #1 chk("reset_outputs", outs(), 0);
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        chk("idle_after_reset", int'(bus.busy), 0);

        // Basic packet with programmable delay
        start_dly = 5'd2;
        wait_cnt = 0; seen_rd = 1'b0; rx_cnt = 0; r0 = rd_count;
        push_pkt(2'd1, 3, 8'h11, 1'b0);
        wait_done(1, 40, "t1_done");
        tick();
        chk("t1_wait_cycles", wait_cnt, 3);
        chk("t1_reads", rd_count - r0, 5);
        chk("t1_rx_bytes", rx_cnt, 5);
        chk("t1_idle", int'(bus.busy), 0);

        // Zero-length packet followed back-to-back by a corrupted-parity packet
        start_dly = 5'd0;
        rx_cnt = 0; r0 = rd_count;
        push_pkt(2'd2, 0, 8'h00, 1'b0);
        push_pkt(2'd0, 2, 8'h5A, 1'b1);
        wait_done(2, 30, "t2_done");
        wait_done(3, 30, "t3_done");
        tick();
        chk("t23_reads", rd_count - r0, 6);
        chk("t23_rx_bytes", rx_cnt, 6);
        chk("t23_no_overread", ovr_count, 0);

        // vld_out withdrawn mid-packet
        rx_cnt = 0; r0 = rd_count;
        push_pkt(2'd3, 6, 8'h07, 1'b0);
        wait_rx(3, 40, "t4_reach_payload2");
        vld_gate = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_read_enb_low", int'(bus.read_enb), 0);
        end
        vld_gate = 1'b1;
        wait_done(4, 40, "t4_done");
        tick();
        chk("t4_reads", rd_count - r0, 8);
        chk("t4_rx_bytes", rx_cnt, 8);

        // Soft reset during a long start delay
        start_dly = 5'd31;
        abort_cnt = 0; r0 = rd_count; d0 = done_cnt;
        push_pkt(2'd1, 1, 8'h33, 1'b0);
        repeat (30) tick();
        chk("t5_still_waiting", int'(bus.busy), 1);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        repeat (3) tick();
        chk("t5_abort_once", abort_cnt, 1);
        chk("t5_busy", int'(bus.busy), 0);
        chk("t5_no_reads", rd_count - r0, 0);
        chk("t5_no_done", done_cnt - d0, 0);
        clear_sb();

        // Asynchronous reset mid-payload, then a clean packet
        start_dly = 5'd1;
        rx_cnt = 0;
        push_pkt(2'd2, 4, 8'h21, 1'b0);
        wait_rx(3, 40, "t6_reach_payload2");
        #2 resetn = 1'b0;
        #1 chk("t6_async_clear", outs(), 0);
        clear_sb();
        a0 = abort_cnt; d0 = done_cnt;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        chk("t6_no_abort_pulse", abort_cnt - a0, 0);
        chk("t6_no_done_pulse", done_cnt - d0, 0);
        push_pkt(2'd3, 2, 8'h44, 1'b0);
        wait_done(d0 + 1, 40, "t6_done");
        tick();

        chk("final_exp_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
